pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the pass-through wiring currently sitting between the IF/DEC/EX/MEM/WB stages of the core. Each instance carries one stage's packed bundle (valid is handled internally, not as a data bit) with a ready/valid handshake, stall via back-pressure, and synchronous flush for branch/jump redirects. An optional two-entry skid mode breaks the combinational ready path between stages. A saturating counter reports how many valid entries flushes have killed.

---
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register carrying one packed stage bundle between two core
// stages with a ready/valid handshake. Stalls by back-pressure and is
// synchronously flushed on branch/jump redirects. An optional two-entry skid
// mode registers in_ready so there is no combinational ready path between
// stages. A saturating counter reports how many valid entries were killed by
// flushes.
//
// Parameters:
//   DATA_W         width of the packed stage bundle
//   SKID           0 = single register, in_ready combinational from out_ready
//                  1 = two-entry skid buffer, in_ready registered
//   CLEAR_ON_FLUSH 1 = data registers zeroed on flush, 0 = only valids cleared
//   CNT_W          width of the flush-drop counter
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   in_valid     upstream holds a valid bundle
//   in_ready     stage can accept this cycle
//   in_data      upstream bundle
//   out_valid    registered bundle valid for downstream
//   out_ready    downstream accepts (0 = stall)
//   out_data     registered bundle
//   flush        kill all held and incoming entries
//   occupancy    number of entries held (0..2)
//   flush_drops  saturating count of valid entries discarded by flush
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W         = 97,
    parameter int SKID           = 0,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_drops
);

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    logic              accept;
    logic              drain;
    logic [1:0]        drop_inc;
    logic [CNT_W+1:0]  drop_sum;

    // In skid mode ready depends only on local state, which breaks the
    // combinational ready chain through the pipeline.
    assign in_ready  = (SKID != 0) ? !skid_valid : (!main_valid || out_ready);

    assign accept    = in_valid && in_ready && !flush;
    assign drain     = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Entries killed by a flush: everything held plus whatever upstream is
    // handing over this cycle (the handshake completes, the data is dropped).
    assign drop_inc  = occupancy + {1'b0, in_valid && in_ready};
    assign drop_sum  = {2'b00, flush_drops} + {{CNT_W{1'b0}}, drop_inc};

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data registers are reset as well, because out_data
            // is visible downstream and must read as zero out of reset.
            main_valid  <= 1'b0;
            main_data   <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            flush_drops <= '0;
        end else begin
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
                if (CLEAR_ON_FLUSH != 0) begin
                    main_data <= '0;
                    skid_data <= '0;
                end
                if (drop_sum > CNT_MAX) begin
                    flush_drops <= CNT_MAX[CNT_W-1:0];
                end else begin
                    flush_drops <= drop_sum[CNT_W-1:0];
                end
            end else if (skid_valid) begin
                // Skid full: in_ready is low, so only a drain can happen and
                // the skid entry moves up to the output.
                if (drain) begin
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!main_valid || drain) begin
                    main_data  <= in_data;
                    main_valid <= 1'b1;
                end else if (SKID != 0) begin
                    // Output is stalled: park the new bundle behind it.
                    skid_data  <= in_data;
                    skid_valid <= 1'b1;
                end
            end else if (drain) begin
                main_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Three instances cover the configurations:
//   a: SKID=0, CLEAR_ON_FLUSH=0, CNT_W=8
//   b: SKID=1, CLEAR_ON_FLUSH=1, CNT_W=8
//   c: SKID=0, CLEAR_ON_FLUSH=1, CNT_W=2
// Inputs are driven 1 ns after the rising edge, outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int W = 97;

    logic clk;
    logic rst;

    int total_cnt;
    int pass_cnt;

    // instance a
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    logic [7:0]   a_drops;
    // instance b
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;
    logic [7:0]   b_drops;
    // instance c
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
    logic [W-1:0] c_in_data, c_out_data;
    logic [1:0]   c_occ;
    logic [1:0]   c_drops;

    pipe_stage_reg #(.DATA_W(W), .SKID(0), .CLEAR_ON_FLUSH(0), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .flush(a_flush), .occupancy(a_occ), .flush_drops(a_drops)
    );

    pipe_stage_reg #(.DATA_W(W), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .flush(b_flush), .occupancy(b_occ), .flush_drops(b_drops)
    );

    pipe_stage_reg #(.DATA_W(W), .SKID(0), .CLEAR_ON_FLUSH(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .flush(c_flush), .occupancy(c_occ), .flush_drops(c_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // {in_ready, out_valid, occupancy, flush_drops, out_data} per instance
        total_cnt++;
        if ({a_in_ready, a_out_valid, a_occ, a_drops, a_out_data} !== {1'b1, 1'b0, 2'd0, 8'd0, {W{1'b0}}})
            $display("FAIL reset_a: got rdy=%b v=%b occ=%0d drops=%0d data=%0h expected rdy=1 v=0 occ=0 drops=0 data=0",
                     a_in_ready, a_out_valid, a_occ, a_drops, a_out_data);
        else pass_cnt++;
        total_cnt++;
        if ({b_in_ready, b_out_valid, b_occ, b_drops, b_out_data} !== {1'b1, 1'b0, 2'd0, 8'd0, {W{1'b0}}})
            $display("FAIL reset_b: got rdy=%b v=%b occ=%0d drops=%0d data=%0h expected rdy=1 v=0 occ=0 drops=0 data=0",
                     b_in_ready, b_out_valid, b_occ, b_drops, b_out_data);
        else pass_cnt++;
        total_cnt++;
        if ({c_in_ready, c_out_valid, c_occ, c_drops, c_out_data} !== {1'b1, 1'b0, 2'd0, 2'd0, {W{1'b0}}})
            $display("FAIL reset_c: got rdy=%b v=%b occ=%0d drops=%0d data=%0h expected rdy=1 v=0 occ=0 drops=0 data=0",
                     c_in_ready, c_out_valid, c_occ, c_drops, c_out_data);
        else pass_cnt++;
    endtask

    task automatic test_stream_single();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = W'(i);
            tick();
            total_cnt++;
            if ({a_out_valid, a_out_data} !== {1'b1, W'(i)})
                $display("FAIL stream_single[%0d]: got v=%b data=%0h expected v=1 data=%0h",
                         i, a_out_valid, a_out_data, i);
            else pass_cnt++;
        end
        a_in_valid = 1'b0;
        tick();
        total_cnt++;
        if ({a_out_valid, a_occ} !== {1'b0, 2'd0})
            $display("FAIL stream_single_end: got v=%b occ=%0d expected v=0 occ=0", a_out_valid, a_occ);
        else pass_cnt++;
    endtask

    task automatic test_stream_skid();
        b_out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = W'(i);
            tick();
            total_cnt++;
            if ({b_out_valid, b_out_data, b_in_ready, b_occ} !== {1'b1, W'(i), 1'b1, 2'd1})
                $display("FAIL stream_skid[%0d]: got v=%b data=%0h rdy=%b occ=%0d expected v=1 data=%0h rdy=1 occ=1",
                         i, b_out_valid, b_out_data, b_in_ready, b_occ, i);
            else pass_cnt++;
        end
        b_in_valid = 1'b0;
        tick();
        total_cnt++;
        if ({b_out_valid, b_occ} !== {1'b0, 2'd0})
            $display("FAIL stream_skid_end: got v=%b occ=%0d expected v=0 occ=0", b_out_valid, b_occ);
        else pass_cnt++;
    endtask

    task automatic test_skid_stall();
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = W'(32'hA);
        tick();                     // A visible
        b_out_ready = 1'b0;
        b_in_data   = W'(32'hB);
        tick();                     // stall 1: B parked in skid
        total_cnt++;
        if ({b_out_valid, b_out_data, b_occ, b_in_ready} !== {1'b1, W'(32'hA), 2'd2, 1'b0})
            $display("FAIL skid_stall_fill: got v=%b data=%0h occ=%0d rdy=%b expected v=1 data=a occ=2 rdy=0",
                     b_out_valid, b_out_data, b_occ, b_in_ready);
        else pass_cnt++;
        b_in_data = W'(32'hC);
        for (int i = 0; i < 2; i++) begin
            tick();                 // stalls 2 and 3: nothing moves
            total_cnt++;
            if ({b_out_valid, b_out_data, b_occ, b_in_ready} !== {1'b1, W'(32'hA), 2'd2, 1'b0})
                $display("FAIL skid_stall_hold[%0d]: got v=%b data=%0h occ=%0d rdy=%b expected v=1 data=a occ=2 rdy=0",
                         i, b_out_valid, b_out_data, b_occ, b_in_ready);
            else pass_cnt++;
        end
        b_out_ready = 1'b1;
        tick();                     // A drains, B moves up, C not yet taken
        total_cnt++;
        if ({b_out_valid, b_out_data, b_occ, b_in_ready} !== {1'b1, W'(32'hB), 2'd1, 1'b1})
            $display("FAIL skid_stall_b: got v=%b data=%0h occ=%0d rdy=%b expected v=1 data=b occ=1 rdy=1",
                     b_out_valid, b_out_data, b_occ, b_in_ready);
        else pass_cnt++;
        tick();                     // C accepted while B drains
        total_cnt++;
        if ({b_out_valid, b_out_data, b_occ} !== {1'b1, W'(32'hC), 2'd1})
            $display("FAIL skid_stall_c: got v=%b data=%0h occ=%0d expected v=1 data=c occ=1",
                     b_out_valid, b_out_data, b_occ);
        else pass_cnt++;
        b_in_valid = 1'b0;
        tick();
        total_cnt++;
        if ({b_out_valid, b_occ} !== {1'b0, 2'd0})
            $display("FAIL skid_stall_empty: got v=%b occ=%0d expected v=0 occ=0", b_out_valid, b_occ);
        else pass_cnt++;
    endtask

    task automatic test_backpressure_single();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = W'(32'h11);
        tick();
        a_out_ready = 1'b0;
        a_in_data   = W'(32'h22);
        #1;
        total_cnt++;
        if (a_in_ready !== 1'b0)
            $display("FAIL bp_ready_low: got rdy=%b expected 0", a_in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({a_out_valid, a_out_data} !== {1'b1, W'(32'h11)})
            $display("FAIL bp_hold: got v=%b data=%0h expected v=1 data=11", a_out_valid, a_out_data);
        else pass_cnt++;
        a_out_ready = 1'b1;
        #1;
        total_cnt++;
        if (a_in_ready !== 1'b1)
            $display("FAIL bp_ready_high: got rdy=%b expected 1", a_in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({a_out_valid, a_out_data, a_occ} !== {1'b1, W'(32'h22), 2'd1})
            $display("FAIL bp_replace: got v=%b data=%0h occ=%0d expected v=1 data=22 occ=1",
                     a_out_valid, a_out_data, a_occ);
        else pass_cnt++;
        a_in_valid = 1'b0;
        tick();
        total_cnt++;
        if (a_out_valid !== 1'b0)
            $display("FAIL bp_drain: got v=%b expected 0", a_out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush_skid();
        // Two held entries; skid full so the concurrent in_valid is not taken
        // and is not counted.
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = W'(32'h1A);
        tick();
        b_in_data   = W'(32'h1B);
        tick();
        b_in_data   = W'(32'h1C);
        b_flush     = 1'b1;
        tick();
        total_cnt++;
        if ({b_out_valid, b_out_data, b_occ, b_drops} !== {1'b0, {W{1'b0}}, 2'd0, 8'd2})
            $display("FAIL flush_full: got v=%b data=%0h occ=%0d drops=%0d expected v=0 data=0 occ=0 drops=2",
                     b_out_valid, b_out_data, b_occ, b_drops);
        else pass_cnt++;
        // One held entry plus a real handshake in the flush cycle: +2.
        b_flush   = 1'b0;
        b_in_data = W'(32'h1D);
        tick();
        b_in_data = W'(32'h1E);
        b_flush   = 1'b1;
        #1;
        total_cnt++;
        if (b_in_ready !== 1'b1)
            $display("FAIL flush_ready_ungated: got rdy=%b expected 1", b_in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({b_out_valid, b_out_data, b_occ, b_drops} !== {1'b0, {W{1'b0}}, 2'd0, 8'd4})
            $display("FAIL flush_accept: got v=%b data=%0h occ=%0d drops=%0d expected v=0 data=0 occ=0 drops=4",
                     b_out_valid, b_out_data, b_occ, b_drops);
        else pass_cnt++;
        // Accept in the cycle after the flush is honoured.
        b_flush     = 1'b0;
        b_out_ready = 1'b1;
        b_in_data   = W'(32'h1F);
        tick();
        total_cnt++;
        if ({b_out_valid, b_out_data} !== {1'b1, W'(32'h1F)})
            $display("FAIL flush_recover: got v=%b data=%0h expected v=1 data=1f", b_out_valid, b_out_data);
        else pass_cnt++;
        b_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_keep_data();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = W'(32'h55);
        tick();
        a_out_ready = 1'b0;
        a_in_data   = W'(32'h66);   // in_ready low, not accepted
        a_flush     = 1'b1;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        total_cnt++;
        if ({a_out_valid, a_out_data, a_occ, a_drops, a_in_ready} !== {1'b0, W'(32'h55), 2'd0, 8'd1, 1'b1})
            $display("FAIL flush_keep: got v=%b data=%0h occ=%0d drops=%0d rdy=%b expected v=0 data=55 occ=0 drops=1 rdy=1",
                     a_out_valid, a_out_data, a_occ, a_drops, a_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        logic [1:0] exp_drops [5];
        exp_drops = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        c_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = W'(i + 1);
            tick();
            c_in_valid = 1'b0;
            c_flush    = 1'b1;
            tick();
            c_flush    = 1'b0;
            total_cnt++;
            if ({c_drops, c_out_valid, c_out_data} !== {exp_drops[i], 1'b0, {W{1'b0}}})
                $display("FAIL saturate[%0d]: got drops=%0d v=%b data=%0h expected drops=%0d v=0 data=0",
                         i, c_drops, c_out_valid, c_out_data, exp_drops[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in_data = W'(32'h40 + i);
            tick();
        end
        total_cnt++;
        if ({b_out_valid, b_out_data, b_drops} !== {1'b1, W'(32'h42), 8'd4})
            $display("FAIL areset_pre: got v=%b data=%0h drops=%0d expected v=1 data=42 drops=4",
                     b_out_valid, b_out_data, b_drops);
        else pass_cnt++;
        b_in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({b_out_valid, b_out_data, b_occ, b_drops} !== {1'b0, {W{1'b0}}, 2'd0, 8'd0})
            $display("FAIL areset_now: got v=%b data=%0h occ=%0d drops=%0d expected v=0 data=0 occ=0 drops=0",
                     b_out_valid, b_out_data, b_occ, b_drops);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (b_in_ready !== 1'b1)
            $display("FAIL areset_ready: got rdy=%b expected 1", b_in_ready);
        else pass_cnt++;
        b_in_valid = 1'b1;
        b_in_data  = W'(32'h77);
        tick();
        b_in_valid = 1'b0;
        total_cnt++;
        if ({b_out_valid, b_out_data} !== {1'b1, W'(32'h77)})
            $display("FAIL areset_first: got v=%b data=%0h expected v=1 data=77", b_out_valid, b_out_data);
        else pass_cnt++;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0; c_flush = 1'b0;
        #2;
        test_reset();
        #10 rst = 1'b1;
        tick();
        test_stream_single();
        test_stream_skid();
        test_skid_stall();
        test_backpressure_single();
        test_flush_skid();
        test_flush_keep_data();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
